// File: rtl/uart_defs.sv
// Shared UART definitions: receiver FSM encoding, frame width and the
// majority-of-3 voter reused by other UART blocks and their checkers.
package uart_defs;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous pin inputs; resets to the idle-high
// line level so a reset never looks like a start bit.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_mvote.sv
// 8N1 UART receiver, LSB first, deciding each bit by a majority of three
// samples around mid-bit; sticky ready/frame_err/overrun cleared by ready_clr.
module uart_rx_mvote
  import uart_defs::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       ready_clr,
  output logic [7:0] data_out,
  output logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int unsigned Half = CLOCKS_PER_PULSE / 2;
  localparam int unsigned CntW = $clog2(CLOCKS_PER_PULSE);
  localparam logic [CntW-1:0] CntMax  = CntW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CntW-1:0] CntSmp0 = CntW'(Half - 1);
  localparam logic [CntW-1:0] CntSmp1 = CntW'(Half);
  localparam logic [CntW-1:0] CntDec  = CntW'(Half + 1);
  localparam logic [2:0]      LastBit = 3'(UART_DATA_BITS - 1);

  logic            rxs;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      samp_q, samp_d;
  logic [7:0]      data_q, data_d;
  logic            ready_q, ready_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            decide, vote, byte_done, stop_bad;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rxs)
  );

  // The third sample is the live rxs at the decision cycle itself.
  assign decide = (cnt_q == CntDec);
  assign vote   = maj3(samp_q[0], samp_q[1], rxs);

  always_comb begin
    samp_d = samp_q;
    if (cnt_q == CntSmp0) samp_d[0] = rxs;
    if (cnt_q == CntSmp1) samp_d[1] = rxs;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        // The cycle that first sees rxs low counts as cnt 0 of the start bit.
        if (!rxs) begin
          state_d = StStart;
          cnt_d   = CntW'(1);
        end
      end
      StStart: begin
        if (decide) begin
          if (vote) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_idx_d = '0;
          end
        end
      end
      StData: begin
        if (decide) begin
          shift_d   = {vote, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LastBit) state_d = StStop;
        end
      end
      StStop: begin
        if (decide) begin
          if (vote) begin
            byte_done = 1'b1;
            state_d   = StIdle;
          end else begin
            stop_bad = 1'b1;
            state_d  = StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        cnt_d = '0;
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Set beats a coincident ready_clr for every flag.
  always_comb begin
    data_d  = byte_done ? shift_q : data_q;
    ready_d = (ready_q & ~ready_clr) | byte_done;
    ferr_d  = (ferr_q & ~ready_clr) | stop_bad;
    ovr_d   = (ovr_q & ~ready_clr) | (byte_done & ready_q & ~ready_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      samp_q    <= 2'b11;
      data_q    <= '0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      samp_q    <= samp_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_out  = data_q;
  assign ready     = ready_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign rx_busy   = (state_q != StIdle);

endmodule

// File: doc/uart_rx_mvote.md
Name: uart_rx_mvote

Overview:
- Standalone UART receiver: 8N1, LSB first, with 3-sample majority voting per bit.
- Sits on the rx pin, or on the loopback net from the transmitter inside the uart top.
- Delivers each byte with a sticky ready flag cleared by ready_clr, and reports framing and overrun errors.
- Bit timing uses the same CLOCKS_PER_PULSE convention as the rest of the uart design.

Parameters:
- CLOCKS_PER_PULSE, 5208, clk cycles per bit (50 MHz / 9600 baud). Must be >= 4.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- rx  input  1  serial line, idle high, asynchronous to clk
- ready_clr  input  1  level; clears ready, frame_err and overrun
- data_out  output  8  last good byte received
- ready  output  1  new byte available (sticky)
- frame_err  output  1  stop bit sampled low (sticky)
- overrun  output  1  byte completed while ready still set (sticky)
- rx_busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset, asserted asynchronously:
  - data_out=0x00, ready=0, frame_err=0, overrun=0, rx_busy=0.
  - FSM in IDLE; bit and cycle counters at 0; both synchronizer flops at 1.
  - Reset mid-frame discards the partial byte.
- rx passes through a 2-flop synchronizer (rxs); all decisions use rxs.
- HALF = CLOCKS_PER_PULSE/2 (integer divide).
- Cycle counter cnt runs 0..CLOCKS_PER_PULSE-1 and wraps.
- Each bit decision is the majority of rxs sampled at cnt = HALF-1, HALF, HALF+1, taken at cnt = HALF+1.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: when rxs=0, go to START with cnt=0.
- START: at the decision point:
  - majority 1 -> false start, return to IDLE.
  - else go to DATA with bit_idx=0; cnt keeps running.
- DATA: each decision shifts the bit into an 8-bit shift register, LSB first. After bit_idx=7, go to STOP.
- STOP: at the decision point:
  - majority 1 -> data_out <= shift register; ready <= 1; go to IDLE immediately. Returning at mid-stop allows back-to-back frames.
  - majority 0 -> frame_err <= 1; data_out and ready unchanged; go to WAIT_IDLE.
- WAIT_IDLE: stay until rxs=1, then go to IDLE.
- Latency: ready rises 1 cycle after the stop decision, i.e. t0 + 9*CLOCKS_PER_PULSE + HALF + 2, where t0 is the cycle rxs first reads 0.
- ready/ready_clr:
  - Any cycle with ready_clr=1 clears ready, frame_err and overrun.
  - If a set event coincides with ready_clr=1, set wins for that flag.
  - With ready_clr tied high, ready is therefore a 1-cycle pulse per byte.
- overrun: set when a byte completes while ready=1 and ready_clr=0. data_out is still overwritten with the new byte.
- No parity; bit count fixed at 8.

Decomposition:
- Shared package/header uart_defs: state encodings, UART_DATA_BITS=8.
- The majority-of-3 function also goes in uart_defs so the transmitter-side bench checker can reuse it.
- Sub-module uart_sync2: 2-flop synchronizer with async reset value 1, shared with other pin inputs.

Test Plan (CLOCKS_PER_PULSE=4, ready_clr=1 unless stated):
- Send 0x01 as an 8N1 frame -> data_out=0x01, ready high exactly 1 cycle at the computed latency, frame_err=0, rx_busy falls in the same cycle.
- Send 0x00..0xFF back-to-back with single stop bits -> 256 ready pulses, each data_out equal to the sent byte, no errors.
- Send 0xA5 with stop bit driven 0, hold rx low 3 bit-times, release, then send 0x3C -> frame_err=1 and data_out unchanged after 0xA5; 0x3C then received with ready.
- Glitch rx low for 1 cycle -> no ready, rx_busy returns to 0 by cnt=HALF+2, data_out unchanged.
- ready_clr=0; send 0x11 then 0x22 -> ready=1, overrun=1, data_out=0x22; a 1-cycle ready_clr pulse clears ready and overrun.
- Assert rst during data bit 4 of 0x77 -> all outputs reset immediately (async, before the next clk edge); after release, 0x5A is received correctly.
